// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Shares one signed serial multiplier between NUM_REQ requesters.
//            Round-robin arbitration. Each granted job is launched with a
//            one-cycle mul_en_o pulse. The block then waits for mul_valid_i
//            and returns the signed product to the requester that owns the
//            job. Only one job is in flight at a time.
// Ports    : clk_i, rst_ni       clock, synchronous active-low reset
//            req_valid_i         per-requester request, held until ready
//            req_a_i, req_b_i    packed signed operands, slice i = requester i
//            req_ready_o         one-hot pulse, operands accepted
//            rsp_valid_o         one-hot pulse, result for its owner
//            rsp_data_o          signed product, held after the response
//            rsp_err_o           timeout flag, qualified by rsp_valid_o
//            busy_o              high in every state except IDLE
//            mul_en_o/a_o/b_o    multiplier start pulse and operands
//            mul_valid_i/s_i     multiplier done and product
// Options  : `define MSA_TIMEOUT_EN enables the WAIT-state watchdog
//            (TIMEOUT_CYC cycles). When it is undefined, WAIT has no limit
//            and rsp_err_o is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [2*WIDTH-1:0]         rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  output logic                       mul_en_o,
  output logic [WIDTH-1:0]           mul_a_o,
  output logic [WIDTH-1:0]           mul_b_o,
  input  logic                       mul_valid_i,
  input  logic [2*WIDTH-1:0]         mul_s_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WIDTH < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mult_share_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [2*WIDTH-1:0]   rsp_data_q;
  logic                 busy_q;
  logic                 mul_en_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;

  logic                 grant_found_d;
  logic [IDX_W-1:0]     grant_idx_d;
  logic [IDX_W:0]       scan_d;
  logic [WIDTH-1:0]     sel_a_d;
  logic [WIDTH-1:0]     sel_b_d;
  logic [IDX_W-1:0]     rr_next_d;

`ifdef MSA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]      to_cnt_q;
  logic                 rsp_err_q;
`endif

  // Round-robin scan: first requester at or above rr_ptr_q, wrapping. The
  // sum stays below 2*NUM_REQ, so one conditional subtract is the modulo.
  always_comb begin
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    scan_d        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_d = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_d >= (IDX_W+1)'(NUM_REQ)) begin
        scan_d = scan_d - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found_d && req_valid_i[scan_d[IDX_W-1:0]]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = scan_d[IDX_W-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_d == IDX_W'(i)) begin
        sel_a_d = req_a_i[i*WIDTH +: WIDTH];
        sel_b_d = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MSA_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      mul_en_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            owner_q     <= grant_idx_d;
            mul_a_q     <= sel_a_d;
            mul_b_q     <= sel_b_d;
            // Registered so both pulses are visible during LAUNCH.
            req_ready_q <= NUM_REQ'(1) << grant_idx_d;
            mul_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          rr_ptr_q <= rr_next_d;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          // mul_valid_i may still be high from the previous job; skip it.
`ifdef MSA_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_valid_i) begin
            rsp_data_q  <= mul_s_i;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
`ifdef MSA_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef MSA_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            // Watchdog expired: respond to the owner with an error.
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q     <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = busy_q;
  assign mul_en_o    = mul_en_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
`ifdef MSA_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Purpose  : Self-checking bench for mult_share_arbiter (4 requesters,
//            10-bit operands). Includes a simple fixed-latency multiplier
//            model, which can be switched off or overridden by a forced
//            valid/product.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 10;
  localparam int MUL_LAT = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     rsp_err;
  logic                     busy;
  logic                     mul_en;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_valid;
  logic [2*WIDTH-1:0]       mul_s;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .mul_en_o(mul_en), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_valid_i(mul_valid), .mul_s_i(mul_s)
  );

  always #5 clk = ~clk;

  // Multiplier model: product presented MUL_LAT cycles after the en pulse.
  logic               model_off = 1'b0;
  logic               force_valid = 1'b0;
  logic [2*WIDTH-1:0] force_s = '0;
  int                 m_cnt = 0;
  logic signed [2*WIDTH-1:0] m_p = '0;

  always @(posedge clk) begin
    if (mul_en && !model_off) begin
      m_cnt <= MUL_LAT;
      m_p   <= $signed(mul_a) * $signed(mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mul_valid = force_valid | (m_cnt == 1);
  assign mul_s     = force_valid ? force_s : m_p;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output logic [3:0] v, output int c);
    c = 0;
    while (req_ready == 4'b0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    v = req_ready;
  endtask

  task automatic wait_rsp(input int bound, output logic [3:0] v, output int c);
    c = 0;
    while (rsp_valid == 4'b0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    v = rsp_valid;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   32'(req_ready), 0);
    check({tag, "_rspv"},    32'(rsp_valid), 0);
    check({tag, "_data"},    32'(rsp_data),  0);
    check({tag, "_err"},     32'(rsp_err),   0);
    check({tag, "_busy"},    32'(busy),      0);
    check({tag, "_mul_en"},  32'(mul_en),    0);
    check({tag, "_mul_a"},   32'(mul_a),     0);
    check({tag, "_mul_b"},   32'(mul_b),     0);
  endtask

  // Expected products for the round-robin operand set below.
  logic [19:0] rr_exp [4];

  // Requests the masked requesters and checks grant order and each result.
  task automatic run_order(input logic [3:0] mask, input int n, input int ord [4]);
    logic [3:0] v;
    int c;
    req_valid = mask;
    for (int j = 0; j < n; j++) begin
      wait_ready(v, c);
      check("rr_ready", 32'(v), 32'(1) << ord[j]);
      req_valid = req_valid & ~v;
      @(negedge clk);
      wait_rsp(40, v, c);
      check("rr_rsp_valid", 32'(v), 32'(1) << ord[j]);
      check("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[ord[j]]));
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  typedef struct {
    int          r;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [3:0] v;
    int c;
    int seen;
    int ord [4];

    vecs[0] = '{2, -10'sd3,   10'sd7,    20'hFFFEB};
    vecs[1] = '{0, -10'sd512, -10'sd512, 20'h40000};
    vecs[2] = '{3, 10'sd511,  -10'sd512, 20'hC0200};
    vecs[3] = '{1, 10'sd0,    10'sd123,  20'h00000};
    vecs[4] = '{3, -10'sd1,   -10'sd1,   20'h00001};
    vecs[5] = '{0, 10'sd100,  -10'sd5,   20'hFFE0C};
    vecs[6] = '{1, 10'sd37,   10'sd19,   20'h002BF};
    rr_exp[0] = 20'h0000C;  //  3 *  4
    rr_exp[1] = 20'hFFFF6;  // -2 *  5
    rr_exp[2] = 20'hFFFC8;  //  7 * -8
    rr_exp[3] = 20'h00051;  // -9 * -9

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-requester jobs from the table.
    for (int t = 0; t < 7; t++) begin
      req_a[vecs[t].r*WIDTH +: WIDTH] = vecs[t].a;
      req_b[vecs[t].r*WIDTH +: WIDTH] = vecs[t].b;
      req_valid = 4'b1 << vecs[t].r;
      wait_ready(v, c);
      check("vec_ready", 32'(v), 32'(1) << vecs[t].r);
      check("vec_mul_en", 32'(mul_en), 1);
      check("vec_mul_a", 32'(mul_a), 32'(vecs[t].a));
      check("vec_mul_b", 32'(mul_b), 32'(vecs[t].b));
      req_valid = '0;
      @(negedge clk);
      check("vec_ready_pulse", 32'(req_ready), 0);
      wait_rsp(40, v, c);
      check("vec_rsp_valid", 32'(v), 32'(1) << vecs[t].r);
      check("vec_rsp_data", 32'(rsp_data), 32'(vecs[t].exp));
      check("vec_rsp_err", 32'(rsp_err), 0);
      check("vec_latency", 32'(c + 1), MUL_LAT + 1);
      @(negedge clk);
      check("vec_rsp_pulse", 32'(rsp_valid), 0);
      check("vec_data_hold", 32'(rsp_data), 32'(vecs[t].exp));
      check("vec_idle_busy", 32'(busy), 0);
    end

    // Round-robin from reset: all four, then only 1 and 3.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a = {10'sd7 ^ 10'd0, 10'd0, 10'd0, 10'd0};
    req_a[0*WIDTH +: WIDTH] = 10'sd3;  req_b[0*WIDTH +: WIDTH] = 10'sd4;
    req_a[1*WIDTH +: WIDTH] = -10'sd2; req_b[1*WIDTH +: WIDTH] = 10'sd5;
    req_a[2*WIDTH +: WIDTH] = 10'sd7;  req_b[2*WIDTH +: WIDTH] = -10'sd8;
    req_a[3*WIDTH +: WIDTH] = -10'sd9; req_b[3*WIDTH +: WIDTH] = -10'sd9;
    ord = '{0, 1, 2, 3};
    run_order(4'b1111, 4, ord);
    ord = '{1, 3, 0, 0};
    run_order(4'b1010, 2, ord);

    // Stale valid: value present through SETTLE must not be taken.
    force_valid = 1'b1;
    force_s = 20'h12345;
    req_valid = 4'b0001;
    wait_ready(v, c);
    check("stale_ready", 32'(v), 1);
    req_valid = '0;
    @(negedge clk);
    check("stale_settle_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    check("stale_wait_rsp", 32'(rsp_valid), 0);
    force_s = 20'h0ABCD;
    wait_rsp(10, v, c);
    check("stale_rsp_valid", 32'(v), 1);
    check("stale_rsp_data", 32'(rsp_data), 32'h0ABCD);
    check("stale_latency", 32'(c), 1);
    force_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in WAIT: outputs clear, no response, pointer back to 0.
    req_valid = 4'b0100;
    wait_ready(v, c);
    check("rst_mid_ready", 32'(v), 32'b0100);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) seen++;
    end
    check("rst_mid_no_rsp", 32'(seen), 0);
    ord = '{0, 3, 0, 0};
    run_order(4'b1001, 2, ord);

    // Watchdog.
    model_off = 1'b1;
    req_valid = 4'b1000;
    wait_ready(v, c);
    check("to_ready", 32'(v), 32'b1000);
    req_valid = '0;
`ifdef MSA_TIMEOUT_EN
    wait_rsp(100, v, c);
    check("to_rsp_valid", 32'(v), 32'b1000);
    check("to_latency", 32'(c), 66);
    check("to_rsp_err", 32'(rsp_err), 1);
    check("to_rsp_data", 32'(rsp_data), 0);
    @(negedge clk);
    check("to_busy_after", 32'(busy), 0);
`else
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) seen++;
    end
    check("nto_no_rsp", 32'(seen), 0);
    check("nto_busy", 32'(busy), 1);
    check("nto_err", 32'(rsp_err), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("nto_busy_reset", 32'(busy), 0);
`endif
    model_off = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
